tmds_gt_gearbox: RTL and testbench



---
 rtl/tmds_gt_gearbox.sv | 174 +++++++++++++++++
 tb/tb_tmds_gt_gearbox.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_gt_gearbox.sv
// Gearbox for three TMDS channels into the 160-bit 4-lane GT word, with R-times bit repeat and a clock lane.
// Optional: define TMDS_GEARBOX_POLARITY_EN to add the per-lane output inversion port lane_invert.
module tmds_gt_gearbox #(
  parameter int IN_SYMS  = 4,
  parameter int BUF_BITS = 80
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [2:0]   ratio_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [119:0] in_data,
`ifdef TMDS_GEARBOX_POLARITY_EN
  input  logic [3:0]   lane_invert,
`endif
  output logic [159:0] out_data,
  output logic         underflow,
  output logic         cfg_error,
  output logic [6:0]   level
);

  localparam int BEAT_BITS = IN_SYMS * 10;
  localparam logic [6:0] BEAT = 7'(BEAT_BITS);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t              state;
  logic [3:0]          ratio_q;
  logic [6:0]          cons_q;
  logic [6:0]          phase;
  logic [BUF_BITS-1:0] bits_q    [3];
  logic [BUF_BITS-1:0] bits_next [3];
  logic                consume;
  logic                accept;
  logic [6:0]          level_next;
  logic [6:0]          phase_next;
  logic [39:0]         clk_word;
  logic [119:0]        data_word;
  logic [159:0]        inv_mask;

  function automatic logic [3:0] ratio_of(input logic [2:0] sel);
    case (sel)
      3'd0:    ratio_of = 4'd1;
      3'd1:    ratio_of = 4'd2;
      3'd2:    ratio_of = 4'd4;
      3'd3:    ratio_of = 4'd5;
      3'd4:    ratio_of = 4'd8;
      3'd5:    ratio_of = 4'd10;
      default: ratio_of = 4'd0;
    endcase
  endfunction

  function automatic logic [6:0] cons_of(input logic [3:0] r);
    case (r)
      4'd2:    cons_of = 7'd20;
      4'd4:    cons_of = 7'd10;
      4'd5:    cons_of = 7'd8;
      4'd8:    cons_of = 7'd5;
      4'd10:   cons_of = 7'd4;
      default: cons_of = 7'd40;
    endcase
  endfunction

  // Clock symbol oversampled by R has period 10R bits, high for the first 5R of them.
  function automatic logic clk_bit(input logic [7:0] pos, input logic [3:0] r);
    case (r)
      4'd2:    clk_bit = (pos % 8'd20)  < 8'd10;
      4'd4:    clk_bit = (pos % 8'd40)  < 8'd20;
      4'd5:    clk_bit = (pos % 8'd50)  < 8'd25;
      4'd8:    clk_bit = (pos % 8'd80)  < 8'd40;
      4'd10:   clk_bit = (pos % 8'd100) < 8'd50;
      default: clk_bit = (pos % 8'd10)  < 8'd5;
    endcase
  endfunction

  function automatic logic [6:0] phase_adv(input logic [6:0] ph, input logic [3:0] r);
    logic [7:0] p;
    p = {1'b0, ph} + 8'd40;
    case (r)
      4'd2:    phase_adv = 7'(p % 8'd20);
      4'd4:    phase_adv = 7'(p % 8'd40);
      4'd5:    phase_adv = 7'(p % 8'd50);
      4'd8:    phase_adv = 7'(p % 8'd80);
      4'd10:   phase_adv = 7'(p % 8'd100);
      default: phase_adv = 7'(p % 8'd10);
    endcase
  endfunction

  function automatic logic [6:0] src_idx(input logic [6:0] i, input logic [3:0] r);
    case (r)
      4'd2:    src_idx = i / 7'd2;
      4'd4:    src_idx = i / 7'd4;
      4'd5:    src_idx = i / 7'd5;
      4'd8:    src_idx = i / 7'd8;
      4'd10:   src_idx = i / 7'd10;
      default: src_idx = i;
    endcase
  endfunction

`ifdef TMDS_GEARBOX_POLARITY_EN
  assign inv_mask = {{40{lane_invert[3]}}, {40{lane_invert[2]}},
                     {40{lane_invert[1]}}, {40{lane_invert[0]}}};
`else
  assign inv_mask = '0;
`endif

  assign in_ready = (state != IDLE) && (level <= BEAT);
  assign accept   = in_valid && in_ready;
  assign consume  = (state == RUN) && (level >= cons_q);

  // Oldest bit sits at bit 0; new beats land directly behind whatever survives this cycle's consumption.
  always_comb begin
    level_next = level + (accept ? BEAT : 7'd0) - (consume ? cons_q : 7'd0);
    phase_next = phase_adv(phase, ratio_q);
    clk_word   = '0;
    data_word  = '0;
    for (int j = 0; j < 40; j++) begin
      clk_word[j] = clk_bit({1'b0, phase} + 8'(j), ratio_q);
      for (int c = 0; c < 3; c++)
        data_word[c*40 + j] = bits_q[c][src_idx(7'(j), ratio_q)];
    end
    for (int c = 0; c < 3; c++) begin
      bits_next[c] = consume ? (bits_q[c] >> cons_q) : bits_q[c];
      if (accept)
        bits_next[c] = bits_next[c] |
                       (BUF_BITS'(in_data[c*40 +: 40]) << (consume ? level - cons_q : level));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ratio_q   <= 4'd1;
      cons_q    <= 7'd40;
      level     <= '0;
      phase     <= '0;
      underflow <= 1'b0;
      cfg_error <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < 3; c++) bits_q[c] <= '0;
    end else if (!enable || state == IDLE) begin
      // Disable and IDLE share the flush; only an enabled IDLE may launch a new run.
      state     <= IDLE;
      level     <= '0;
      phase     <= '0;
      underflow <= 1'b0;
      cfg_error <= 1'b0;
      out_data  <= inv_mask;
      for (int c = 0; c < 3; c++) bits_q[c] <= '0;
      if (enable) begin
        if (ratio_of(ratio_sel) != 4'd0) begin
          ratio_q <= ratio_of(ratio_sel);
          cons_q  <= cons_of(ratio_of(ratio_sel));
          state   <= PRIME;
        end else begin
          cfg_error <= 1'b1;
        end
      end
    end else begin
      level <= level_next;
      phase <= phase_next;
      for (int c = 0; c < 3; c++) bits_q[c] <= bits_next[c];
      if (state == PRIME) begin
        out_data <= {clk_word, 120'b0} ^ inv_mask;
        if (level_next >= BEAT) state <= RUN;
      end else begin
        out_data <= {clk_word, (consume ? data_word : 120'b0)} ^ inv_mask;
        if (!consume) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_gt_gearbox.sv
// Directed testbench for tmds_gt_gearbox: reset, R=1/4/5/10 streams, underflow, disable and config error.
`timescale 1ns/1ps
module tb_tmds_gt_gearbox;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [2:0]   ratio_sel;
  logic         in_valid;
  logic         in_ready;
  logic [119:0] in_data;
  logic [159:0] out_data;
  logic         underflow;
  logic         cfg_error;
  logic [6:0]   level;
  logic [39:0]  lane0, lane1, lane3;

  int tests = 0;
  int fails = 0;

  // Clock words for phases 0,40,80,20,60 (R=10) and 0,40,30,20,10 (R=5).
  localparam logic [39:0] CLK10 [5] = '{40'hFFFFFFFFFF, 40'h00000003FF, 40'hFFFFF00000,
                                        40'h003FFFFFFF, 40'h0000000000};
  localparam logic [39:0] CLK5  [5] = '{40'h0001FFFFFF, 40'h07FFFFFC00, 40'hFFFFF00000,
                                        40'hFFC000001F, 40'h0000007FFF};
  // Channel 0 beat 40'h5500FF8001 at R=5: bytes 01,80,FF,00,55 each bit repeated five times.
  localparam logic [39:0] DAT5  [5] = '{40'h000000001F, 40'hF800000000, 40'hFFFFFFFFFF,
                                        40'h0000000000, 40'h07C1F07C1F};

  always #5 clock = ~clock;

  assign lane0 = out_data[39:0];
  assign lane1 = out_data[79:40];
  assign lane3 = out_data[159:120];

  tmds_gt_gearbox dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .ratio_sel  (ratio_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef TMDS_GEARBOX_POLARITY_EN
    .lane_invert(4'b0000),
`endif
    .out_data   (out_data),
    .underflow  (underflow),
    .cfg_error  (cfg_error),
    .level      (level)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; ratio_sel = 3'd0; in_valid = 1'b1; in_data = '1;
    tick(); tick();
    tests++; if (out_data !== 160'h0) begin fails++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_underflow got %b want 0", underflow); end
    tests++; if (cfg_error !== 1'b0) begin fails++; $display("[TB] FAIL reset_cfg_error got %b want 0", cfg_error); end
    tests++; if (level !== 7'd0) begin fails++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
  endtask

  task automatic test_r1_stream();
    ratio_sel = 3'd0; enable = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = {40'hFEDCBA9876, 40'h123456789A, 40'h003FF003FF};
    tick();
    tests++; if (lane3 !== 40'h07C1F07C1F) begin fails++; $display("[TB] FAIL r1_prime_clk got %h want 07c1f07c1f", lane3); end
    tests++; if (lane0 !== 40'h0) begin fails++; $display("[TB] FAIL r1_prime_data got %h want 0", lane0); end
    tests++; if (level !== 7'd40) begin fails++; $display("[TB] FAIL r1_prime_level got %0d want 40", level); end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++; if (lane0 !== 40'h003FF003FF) begin fails++; $display("[TB] FAIL r1_lane0[%0d] got %h want 003ff003ff", i, lane0); end
      tests++; if (lane1 !== 40'h123456789A) begin fails++; $display("[TB] FAIL r1_lane1[%0d] got %h want 123456789a", i, lane1); end
      tests++; if (lane3 !== 40'h07C1F07C1F) begin fails++; $display("[TB] FAIL r1_clk[%0d] got %h want 07c1f07c1f", i, lane3); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL r1_ready[%0d] got %b want 1", i, in_ready); end
      tests++; if (level !== 7'd40) begin fails++; $display("[TB] FAIL r1_level[%0d] got %0d want 40", i, level); end
      tests++; if (underflow !== 1'b0) begin fails++; $display("[TB] FAIL r1_underflow[%0d] got %b want 0", i, underflow); end
    end
    // Reset while running must land on reset values at once.
    reset = 1'b1;
    tick();
    tests++; if (out_data !== 160'h0) begin fails++; $display("[TB] FAIL midrun_reset_out got %h want 0", out_data); end
    tests++; if (level !== 7'd0) begin fails++; $display("[TB] FAIL midrun_reset_level got %0d want 0", level); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL midrun_reset_ready got %b want 0", in_ready); end
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
  endtask

  task automatic test_r10_single();
    int exp_lvl;
    ratio_sel = 3'd5; enable = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 120'h1;
    tick();
    in_valid = 1'b0; in_data = '0;
    tests++; if (lane3 !== CLK10[0]) begin fails++; $display("[TB] FAIL r10_prime_clk got %h want %h", lane3, CLK10[0]); end
    tests++; if (level !== 7'd40) begin fails++; $display("[TB] FAIL r10_prime_level got %0d want 40", level); end
    for (int k = 0; k < 11; k++) begin
      tick();
      exp_lvl = (k < 10) ? 36 - 4 * k : 0;
      tests++; if (lane3 !== CLK10[(k+1)%5]) begin fails++; $display("[TB] FAIL r10_clk[%0d] got %h want %h", k, lane3, CLK10[(k+1)%5]); end
      tests++; if (lane0 !== ((k == 0) ? 40'h00000003FF : 40'h0)) begin fails++; $display("[TB] FAIL r10_lane0[%0d] got %h", k, lane0); end
      tests++; if (underflow !== (k >= 10)) begin fails++; $display("[TB] FAIL r10_underflow[%0d] got %b want %b", k, underflow, (k >= 10)); end
      tests++; if (level !== 7'(exp_lvl)) begin fails++; $display("[TB] FAIL r10_level[%0d] got %0d want %0d", k, level, exp_lvl); end
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_r5_underflow();
    ratio_sel = 3'd3; enable = 1'b1;
    tick();
    in_valid = 1'b1; in_data = {40'h0, 40'hFFFFFFFFFF, 40'h5500FF8001};
    tick();
    in_valid = 1'b0; in_data = '0;
    tests++; if (lane3 !== CLK5[0]) begin fails++; $display("[TB] FAIL r5_prime_clk got %h want %h", lane3, CLK5[0]); end
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++; if (lane3 !== CLK5[(k+1)%5]) begin fails++; $display("[TB] FAIL r5_clk[%0d] got %h want %h", k, lane3, CLK5[(k+1)%5]); end
      tests++; if (lane0 !== ((k < 5) ? DAT5[k] : 40'h0)) begin fails++; $display("[TB] FAIL r5_lane0[%0d] got %h", k, lane0); end
      tests++; if (lane1 !== ((k < 5) ? 40'hFFFFFFFFFF : 40'h0)) begin fails++; $display("[TB] FAIL r5_lane1[%0d] got %h", k, lane1); end
      tests++; if (underflow !== (k == 5)) begin fails++; $display("[TB] FAIL r5_underflow[%0d] got %b want %b", k, underflow, (k == 5)); end
      tests++; if (level !== ((k < 5) ? 7'(32 - 8 * k) : 7'd0)) begin fails++; $display("[TB] FAIL r5_level[%0d] got %0d", k, level); end
    end
  endtask

  task automatic test_disable_restart();
    in_valid = 1'b1; in_data = {3{40'hA5A5A5A5A5}};
    tick();
    in_valid = 1'b0; in_data = '0;
    tests++; if (level !== 7'd40) begin fails++; $display("[TB] FAIL refill_level got %0d want 40", level); end
    tests++; if (underflow !== 1'b1) begin fails++; $display("[TB] FAIL sticky_underflow got %b want 1", underflow); end
    enable = 1'b0;
    tick();
    tests++; if (level !== 7'd0) begin fails++; $display("[TB] FAIL disable_level got %0d want 0", level); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("[TB] FAIL disable_underflow got %b want 0", underflow); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL disable_ready got %b want 0", in_ready); end
    tests++; if (out_data !== 160'h0) begin fails++; $display("[TB] FAIL disable_out got %h want 0", out_data); end
    ratio_sel = 3'd3; enable = 1'b1;
    tick();
    tick();
    tests++; if (lane3 !== CLK5[0]) begin fails++; $display("[TB] FAIL restart_phase0 got %h want %h", lane3, CLK5[0]); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL restart_ready got %b want 1", in_ready); end
    tick();
    tests++; if (lane3 !== CLK5[1]) begin fails++; $display("[TB] FAIL restart_phase40 got %h want %h", lane3, CLK5[1]); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_cfg_error();
    ratio_sel = 3'd6; enable = 1'b1;
    tick();
    tests++; if (cfg_error !== 1'b1) begin fails++; $display("[TB] FAIL cfg_error_set got %b want 1", cfg_error); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL cfg_ready got %b want 0", in_ready); end
    tests++; if (out_data !== 160'h0) begin fails++; $display("[TB] FAIL cfg_out got %h want 0", out_data); end
    tick();
    tests++; if (cfg_error !== 1'b1) begin fails++; $display("[TB] FAIL cfg_error_hold got %b want 1", cfg_error); end
    ratio_sel = 3'd2;
    tick();
    tests++; if (cfg_error !== 1'b0) begin fails++; $display("[TB] FAIL cfg_error_clear got %b want 0", cfg_error); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL cfg_prime_ready got %b want 1", in_ready); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_r4_scoreboard();
    bit          q[$];
    int          lvl = 0;
    int          sent = 0;
    bit          run = 1'b0;
    bit          uf = 1'b0;
    bit          acc, cons;
    logic [39:0] beat, exp_w;
    logic [9:0]  chunk;
    exp_w = '0;
    ratio_sel = 3'd2; enable = 1'b1;
    tick();
    for (int cyc = 0; cyc < 40; cyc++) begin
      beat     = 40'hC3A596F01E ^ (40'(sent) * 40'h0F1E2D3C4B);
      in_valid = (sent < 8);
      in_data  = {40'h0, ~beat, beat};
      tests++; if (in_ready !== (lvl <= 40)) begin fails++; $display("[TB] FAIL r4_ready[%0d] got %b want %b", cyc, in_ready, (lvl <= 40)); end
      acc  = in_valid && (lvl <= 40);
      cons = run && (lvl >= 10);
      if (cons) begin
        for (int b = 0; b < 10; b++) chunk[b] = q.pop_front();
        for (int j = 0; j < 40; j++) exp_w[j] = chunk[j/4];
      end
      if (run && !cons) uf = 1'b1;
      lvl = lvl + (acc ? 40 : 0) - (cons ? 10 : 0);
      if (acc) begin
        for (int b = 0; b < 40; b++) q.push_back(beat[b]);
        sent++;
      end
      if (!run && lvl >= 40) run = 1'b1;
      tick();
      tests++; if (level !== 7'(lvl)) begin fails++; $display("[TB] FAIL r4_level[%0d] got %0d want %0d", cyc, level, lvl); end
      tests++; if (underflow !== uf) begin fails++; $display("[TB] FAIL r4_underflow[%0d] got %b want %b", cyc, underflow, uf); end
      if (cons) begin
        tests++; if (lane0 !== exp_w) begin fails++; $display("[TB] FAIL r4_lane0[%0d] got %h want %h", cyc, lane0, exp_w); end
        tests++; if (lane1 !== ~exp_w) begin fails++; $display("[TB] FAIL r4_lane1[%0d] got %h want %h", cyc, lane1, ~exp_w); end
      end
    end
    in_valid = 1'b0; in_data = '0; enable = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ratio_sel = 3'd0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_r1_stream();
    test_r10_single();
    test_r5_underflow();
    test_disable_restart();
    test_cfg_error();
    test_r4_scoreboard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
